// File: rtl/alm_mult_pipe.sv
// alm_mult_pipe
// Pipelined Mitchell-style approximate log multiplier (ALM).
// Each operand is reduced to a leading-one index k and a fixed-point fraction.
// The fractions are truncated to M bits with set-one compensation. The k values
// and the fractions are then added. A piecewise-linear antilog turns the sum
// back into an approximate product.
//
// Pipeline: 3 stages, all advancing together on a global enable.
//   stage 1 : sign / magnitude / leading-one detect / fraction encode + truncate
//   stage 2 : fraction sum S and exponent sum E
//   stage 3 : antilog, zero forcing, sign restore -> output register
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     operand valid
//   in_ready     operand ready (= !out_valid || out_ready)
//   in_a, in_b   operands, WIDTH bits
//   in_signed    1: operands are two's complement, 0: unsigned
//   in_tag       sideband tag carried with the transaction
//   out_valid    result valid
//   out_ready    downstream ready
//   out_product  approximate product, 2*WIDTH bits
//   out_tag      tag of the transaction on out_product
module alm_mult_pipe #(
  parameter int WIDTH = 16,
  parameter int M     = 6,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int F  = WIDTH - 1;            // fraction bits
  localparam int KW = $clog2(WIDTH);        // leading-one index width
  localparam int EW = KW + 1;               // exponent sum width
  localparam int SW = 2 * WIDTH + F + 1;    // antilog shifter width

  localparam logic [EW:0] ONE_SH = 1;

  // Whole pipe stalls together; a stage only moves when the output can drain.
  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // ---------------------------------------------------------------------------
  // Stage 1 combinational encode, one copy per operand
  // ---------------------------------------------------------------------------
  logic [1:0][WIDTH-1:0] opnd;
  logic [1:0][F-1:0]     frac_raw;
  logic [1:0][F-1:0]     frac_trunc;
  logic [1:0][KW-1:0]    lead;
  logic [1:0]            nonzero;

  assign opnd[0] = in_a;
  assign opnd[1] = in_b;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_enc
      logic [WIDTH:0]  mag;
      logic [KW-1:0]   k;
      logic [WIDTH:0]  rem;

      always_comb begin
        // WIDTH+1 bits so the most negative operand keeps its full magnitude.
        mag = (in_signed && opnd[gi][WIDTH-1]) ? -{1'b1, opnd[gi]} : {1'b0, opnd[gi]};
        k = '0;
        for (int i = 0; i < WIDTH; i++) begin
          if (mag[i]) k = KW'(i);
        end
        // Strip the leading one, then left-align the remainder into F bits.
        rem = mag ^ ((WIDTH + 1)'(1) << k);
        frac_raw[gi] = F'(rem << (F - int'(k)));
      end

      assign lead[gi]    = k;
      assign nonzero[gi] = |mag;

      if (M < F) begin : g_trunc
        // Keep the top M fraction bits and put a one just below them, which
        // centres the truncation error instead of always rounding down.
        localparam logic [F-1:0] LOW_MASK = F'((64'd1 << (F - M)) - 64'd1);
        localparam logic [F-1:0] SET_BIT  = F'(64'd1 << (F - M - 1));
        assign frac_trunc[gi] = (frac_raw[gi] & ~LOW_MASK) | SET_BIT;
      end else begin : g_full
        assign frac_trunc[gi] = frac_raw[gi];
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------------
  logic             v1, sg1, z1;
  logic [F-1:0]     fa1, fb1;
  logic [KW-1:0]    ka1, kb1;
  logic [TAG_W-1:0] tag1;

  logic             v2, sg2, z2;
  logic [F:0]       s2;
  logic [EW-1:0]    e2;
  logic [TAG_W-1:0] tag2;

  // ---------------------------------------------------------------------------
  // Stage 3 combinational antilog
  // ---------------------------------------------------------------------------
  logic [SW-1:0]      mant_w;
  logic [EW:0]        shamt;
  logic [2*WIDTH-1:0] mag_p;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    // S below 2^F: mantissa 1.S scaled by 2^E.
    // S at or above 2^F: the carry already supplies the integer one, so S is
    // used directly with one extra doubling.
    if (s2[F]) begin
      mant_w = SW'(s2);
      shamt  = {1'b0, e2} + ONE_SH;
    end else begin
      mant_w = SW'({1'b1, s2[F-1:0]});
      shamt  = {1'b0, e2};
    end
    mag_p = (2 * WIDTH)'((mant_w << shamt) >> F);
    if (z2)       prod = '0;
    else if (sg2) prod = -mag_p;
    else          prod = mag_p;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1          <= 1'b0;
      sg1         <= 1'b0;
      z1          <= 1'b0;
      fa1         <= '0;
      fb1         <= '0;
      ka1         <= '0;
      kb1         <= '0;
      tag1        <= '0;
      v2          <= 1'b0;
      sg2         <= 1'b0;
      z2          <= 1'b0;
      s2          <= '0;
      e2          <= '0;
      tag2        <= '0;
      out_valid   <= 1'b0;
      out_product <= '0;
      out_tag     <= '0;
    end else if (en) begin
      // Stage 1
      v1   <= in_valid;
      fa1  <= frac_trunc[0];
      fb1  <= frac_trunc[1];
      ka1  <= lead[0];
      kb1  <= lead[1];
      sg1  <= in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
      z1   <= !(nonzero[0] && nonzero[1]);
      tag1 <= in_tag;
      // Stage 2
      v2   <= v1;
      s2   <= {1'b0, fa1} + {1'b0, fb1};
      e2   <= {1'b0, ka1} + {1'b0, kb1};
      sg2  <= sg1;
      z2   <= z1;
      tag2 <= tag1;
      // Stage 3
      out_valid   <= v2;
      out_product <= prod;
      out_tag     <= tag2;
    end
  end

endmodule

// File: tb/tb_alm_mult_pipe.sv
// tb_alm_mult_pipe
// Self-checking bench for alm_mult_pipe. Three WIDTH=8 instances (M = 7, 3, 1)
// and one WIDTH=16, M=6 instance are driven in lockstep from shared handshake
// signals. Expected products come from an arithmetic reference model of the
// approximate log multiplication; a queue holds expected results in order.
module tb_alm_mult_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_signed = 1'b0;
  logic        out_ready = 1'b1;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic [15:0] a16 = '0;
  logic [15:0] b16 = '0;
  logic [3:0]  tag = '0;

  logic        rdy8 [3];
  logic        vld8 [3];
  logic [15:0] p8 [3];
  logic [3:0]  t8 [3];
  logic        rdy16;
  logic        vld16;
  logic [31:0] p16;
  logic [3:0]  t16;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct packed {
    logic [2:0][15:0] e8;
    logic [31:0]      e16;
    logic [3:0]       tag;
    logic [31:0]      cyc;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut8
      alm_mult_pipe #(
        .WIDTH(8),
        .M((gi == 0) ? 7 : ((gi == 1) ? 3 : 1)),
        .TAG_W(4)
      ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(rdy8[gi]),
        .in_a(a8), .in_b(b8), .in_signed(in_signed), .in_tag(tag),
        .out_valid(vld8[gi]), .out_ready(out_ready),
        .out_product(p8[gi]), .out_tag(t8[gi])
      );
    end
  endgenerate

  alm_mult_pipe #(.WIDTH(16), .M(6), .TAG_W(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(rdy16),
    .in_a(a16), .in_b(b16), .in_signed(in_signed), .in_tag(tag),
    .out_valid(vld16), .out_ready(out_ready),
    .out_product(p16), .out_tag(t16)
  );

  function automatic int m_of(int i);
    return (i == 0) ? 7 : ((i == 1) ? 3 : 1);
  endfunction

  // Reference: approximate product computed from the log-multiplication rules.
  function automatic longint unsigned model(int w, int m, longint unsigned a,
                                            longint unsigned b, bit sgn);
    longint unsigned ma, mb, fa, fb, s, p, one_f;
    int f, ka, kb, e;
    bit na, nb;
    f  = w - 1;
    na = sgn && (((a >> (w - 1)) & 64'd1) == 64'd1);
    nb = sgn && (((b >> (w - 1)) & 64'd1) == 64'd1);
    ma = na ? ((64'd1 << w) - a) : a;
    mb = nb ? ((64'd1 << w) - b) : b;
    if (ma == 0 || mb == 0) return 64'd0;
    ka = 0;
    while ((ma >> (ka + 1)) != 0) ka++;
    kb = 0;
    while ((mb >> (kb + 1)) != 0) kb++;
    fa = (ma - (64'd1 << ka)) * (64'd1 << (f - ka));
    fb = (mb - (64'd1 << kb)) * (64'd1 << (f - kb));
    if (m < f) begin
      fa = (fa / (64'd1 << (f - m))) * (64'd1 << (f - m)) + (64'd1 << (f - 1 - m));
      fb = (fb / (64'd1 << (f - m))) * (64'd1 << (f - m)) + (64'd1 << (f - 1 - m));
    end
    s = fa + fb;
    e = ka + kb;
    one_f = 64'd1 << f;
    if (s < one_f) p = ((one_f + s) << e) >> f;
    else           p = (s << (e + 1)) >> f;
    if (na ^ nb) p = ((64'd1 << (2 * w)) - p) & ((64'd1 << (2 * w)) - 64'd1);
    return p;
  endfunction

  // Advance one clock; record the expected result of any accepted transaction.
  task automatic tick();
    exp_t e;
    if (in_valid && rdy8[0]) begin
      for (int i = 0; i < 3; i++) e.e8[i] = 16'(model(8, m_of(i), 64'(a8), 64'(b8), in_signed));
      e.e16 = 32'(model(16, 6, 64'(a16), 64'(b16), in_signed));
      e.tag = tag;
      e.cyc = 32'(cyc);
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [7:0] pick8();
    int sel;
    sel = int'($urandom_range(0, 7));
    if (sel == 0) return 8'h00;
    if (sel == 1) return 8'h80;
    if (sel == 2) return 8'hFF;
    return 8'($urandom);
  endfunction

  task automatic drive_rand(input logic v);
    in_valid  = v;
    a8        = pick8();
    b8        = pick8();
    a16       = ($urandom_range(0, 5) == 0) ? 16'h8000 : 16'($urandom);
    b16       = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
    in_signed = 1'($urandom);
    tag       = 4'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (vld8[i] !== 1'b0 || p8[i] !== 16'h0 || t8[i] !== 4'h0 || rdy8[i] !== 1'b1) begin
        bad++;
        $display("FAIL reset_state%0d: valid=%b prod=%h tag=%h ready=%b required 0/0000/0/1",
                 i, vld8[i], p8[i], t8[i], rdy8[i]);
      end
    end
    total++;
    if (vld16 !== 1'b0 || p16 !== 32'h0 || t16 !== 4'h0 || rdy16 !== 1'b1) begin
      bad++;
      $display("FAIL reset_state16: valid=%b prod=%h tag=%h ready=%b", vld16, p16, t16, rdy16);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    int va [5] = '{13, 255, 128, 0, 0};
    int vb [5] = '{11, 255, 2, 197, 55};
    int vs [5] = '{0, 0, 1, 1, 0};
    int e7 [5] = '{128, 65024, 65280, 0, 0};
    int e3 [5] = '{144, 61440, 65248, 0, 0};
    int lat;
    exp_t e;
    out_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      in_valid  = 1'b1;
      a8        = 8'(va[n]);
      b8        = 8'(vb[n]);
      in_signed = 1'(vs[n]);
      tag       = 4'(n + 1);
      a16       = 16'($urandom);
      b16       = 16'($urandom);
      #1;
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!vld8[0] && lat < 8) begin
        #1;
        tick();
        lat++;
      end
      total++;
      if (lat != 3) begin
        bad++;
        $display("FAIL vec%0d_latency: got=%0d required=3", n, lat);
      end
      total++;
      if (p8[0] !== 16'(e7[n])) begin
        bad++;
        $display("FAIL vec%0d_m7: got=%h required=%h", n, p8[0], 16'(e7[n]));
      end
      total++;
      if (p8[1] !== 16'(e3[n])) begin
        bad++;
        $display("FAIL vec%0d_m3: got=%h required=%h", n, p8[1], 16'(e3[n]));
      end
      total++;
      if (t8[0] !== 4'(n + 1) || t16 !== 4'(n + 1)) begin
        bad++;
        $display("FAIL vec%0d_tag: got=%h/%h required=%h", n, t8[0], t16, 4'(n + 1));
      end
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL vec%0d_queue: got=empty required=1 entry", n);
      end else begin
        e = q.pop_front();
        if (p8[2] !== e.e8[2] || p16 !== e.e16) begin
          bad++;
          $display("FAIL vec%0d_model: got m1=%h w16=%h required m1=%h w16=%h",
                   n, p8[2], p16, e.e8[2], e.e16);
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int got = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (c < 20) drive_rand(1'b1);
      else        in_valid = 1'b0;
      #1;
      total++;
      if (rdy8[0] !== 1'b1 || vld16 !== vld8[0]) begin
        bad++;
        $display("FAIL b2b_ready: ready=%b v16=%b v8=%b required ready=1 v16=v8", rdy8[0], vld16, vld8[0]);
      end
      if (vld8[0]) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL b2b_extra: out_valid=1 required=0");
        end else begin
          e = q.pop_front();
          got++;
          if (32'(cyc) - e.cyc != 32'd3) begin
            bad++;
            $display("FAIL b2b_latency: got=%0d required=3", 32'(cyc) - e.cyc);
          end
          for (int i = 0; i < 3; i++) begin
            total++;
            if (p8[i] !== e.e8[i]) begin
              bad++;
              $display("FAIL b2b_prod_m%0d: got=%h required=%h", m_of(i), p8[i], e.e8[i]);
            end
          end
          total++;
          if (p16 !== e.e16 || t8[0] !== e.tag || t16 !== e.tag) begin
            bad++;
            $display("FAIL b2b_w16_tag: got prod=%h tag=%h/%h required prod=%h tag=%h",
                     p16, t8[0], t16, e.e16, e.tag);
          end
        end
      end
      tick();
    end
    total++;
    if (got != 20) begin
      bad++;
      $display("FAIL b2b_count: got=%0d required=20", got);
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int sent = 0;
    int got = 0;
    int guard = 0;
    logic pend = 1'b0;
    logic prev_stall = 1'b0;
    logic [15:0] prev_p = '0;
    logic [3:0] prev_t = '0;
    while (got < 10 && guard < 300) begin
      if (!pend && sent < 10 && $urandom_range(0, 3) != 0) begin
        drive_rand(1'b1);
        tag  = 4'(sent);
        pend = 1'b1;
      end else if (!pend) begin
        in_valid = 1'b0;
      end
      out_ready = 1'($urandom);
      #1;
      total++;
      if (rdy8[0] !== (!vld8[0] || out_ready) || rdy16 !== rdy8[0]) begin
        bad++;
        $display("FAIL bp_ready: got=%b required=%b", rdy8[0], !vld8[0] || out_ready);
      end
      if (prev_stall) begin
        total++;
        if (vld8[0] !== 1'b1 || p8[0] !== prev_p || t8[0] !== prev_t) begin
          bad++;
          $display("FAIL bp_hold: got v=%b p=%h t=%h required v=1 p=%h t=%h",
                   vld8[0], p8[0], t8[0], prev_p, prev_t);
        end
      end
      if (vld8[0] && out_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL bp_extra: out_valid=1 required=0");
        end else begin
          e = q.pop_front();
          got++;
          if (p8[0] !== e.e8[0] || p8[1] !== e.e8[1] || p8[2] !== e.e8[2] ||
              p16 !== e.e16 || t8[0] !== e.tag) begin
            bad++;
            $display("FAIL bp_result: got %h %h %h %h tag=%h required %h %h %h %h tag=%h",
                     p8[0], p8[1], p8[2], p16, t8[0], e.e8[0], e.e8[1], e.e8[2], e.e16, e.tag);
          end
        end
      end
      prev_stall = vld8[0] && !out_ready;
      prev_p     = p8[0];
      prev_t     = t8[0];
      if (in_valid && rdy8[0]) begin
        sent++;
        pend = 1'b0;
      end
      tick();
      guard++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    total++;
    if (got != 10 || q.size() != 0) begin
      bad++;
      $display("FAIL bp_count: got=%0d left=%0d required 10/0", got, q.size());
    end
  endtask

  task automatic test_reset_midstream();
    exp_t e;
    int lat;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drive_rand(1'b1);
      #1;
      tick();
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (vld8[i] !== 1'b0 || p8[i] !== 16'h0 || t8[i] !== 4'h0) begin
        bad++;
        $display("FAIL mid_reset%0d: valid=%b prod=%h tag=%h required 0/0000/0", i, vld8[i], p8[i], t8[i]);
      end
    end
    total++;
    if (vld16 !== 1'b0 || p16 !== 32'h0 || rdy8[0] !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset16: valid=%b prod=%h ready=%b required 0/0/1", vld16, p16, rdy8[0]);
    end
    q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      total++;
      if (vld8[0] !== 1'b0 || vld16 !== 1'b0) begin
        bad++;
        $display("FAIL mid_stale: out_valid=%b/%b required=0", vld8[0], vld16);
      end
      tick();
    end
    drive_rand(1'b1);
    #1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!vld8[0] && lat < 8) begin
      #1;
      tick();
      lat++;
    end
    total++;
    if (lat != 3) begin
      bad++;
      $display("FAIL mid_latency: got=%0d required=3", lat);
    end
    total++;
    if (q.size() != 1) begin
      bad++;
      $display("FAIL mid_queue: got=%0d entries required=1", q.size());
    end else begin
      e = q.pop_front();
      if (p8[0] !== e.e8[0] || p8[1] !== e.e8[1] || p8[2] !== e.e8[2] || p16 !== e.e16) begin
        bad++;
        $display("FAIL mid_result: got %h %h %h %h required %h %h %h %h",
                 p8[0], p8[1], p8[2], p16, e.e8[0], e.e8[1], e.e8[2], e.e16);
      end
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
